// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 3-sample majority vote per bit, false-start rejection,
// parity/framing/break flags and a one-entry valid/ready output buffer with overrun pulse.
module uart_rx_cfg #(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            rx_ready,
    output logic            rx_valid,
    output logic [DBIT-1:0] rx_data,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det,
    output logic            overrun
);

    localparam int             SW          = $clog2(OVERSAMPLE);
    localparam int             M           = OVERSAMPLE / 2;
    localparam logic [SW-1:0]  S_V0        = SW'(M - 1);
    localparam logic [SW-1:0]  S_V1        = SW'(M);
    localparam logic [SW-1:0]  S_V2        = SW'(M + 1);
    localparam logic [SW-1:0]  S_LAST      = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]     N_DATA_LAST = 4'(DBIT - 1);
    localparam logic [3:0]     N_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic           PEN         = (PARITY_EN != 0);
    localparam logic           PODD        = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    state_t            state_reg, state_next;
    logic              rx_meta_reg, rx_s_reg;
    logic [SW-1:0]     s_reg, s_next;
    logic [3:0]        n_reg, n_next;
    logic [1:0]        samp_reg, samp_next;
    logic [DBIT-1:0]   shift_reg, shift_next;
    logic              par_reg, par_next;
    logic              stop_err_reg, stop_err_next;

    logic vote, vote_now, bit_end;
    logic done, done_perr, done_ferr, done_brk;

    // Third sample is the live synchronized line at s = M+1.
    assign vote     = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s_reg) | (samp_reg[1] & rx_s_reg);
    assign vote_now = s_tick && (s_reg == S_V2);
    assign bit_end  = s_tick && (s_reg == S_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg  <= 1'b1;
            rx_s_reg     <= 1'b1;
            state_reg    <= IDLE;
            s_reg        <= '0;
            n_reg        <= '0;
            samp_reg     <= '0;
            shift_reg    <= '0;
            par_reg      <= 1'b0;
            stop_err_reg <= 1'b0;
        end else begin
            rx_meta_reg  <= rx;
            rx_s_reg     <= rx_meta_reg;
            state_reg    <= state_next;
            s_reg        <= s_next;
            n_reg        <= n_next;
            samp_reg     <= samp_next;
            shift_reg    <= shift_next;
            par_reg      <= par_next;
            stop_err_reg <= stop_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        s_next        = s_reg;
        n_next        = n_reg;
        samp_next     = samp_reg;
        shift_next    = shift_reg;
        par_next      = par_reg;
        stop_err_next = stop_err_reg;
        done          = 1'b0;
        done_ferr     = stop_err_reg | ~vote;
        done_brk      = (shift_reg == '0) && (!PEN || !par_reg) && !vote;
        done_perr     = PEN && (par_reg != (^shift_reg ^ PODD));

        if (s_tick && (state_reg inside {START, DATA, PARITY, STOP})) begin
            s_next = (s_reg == S_LAST) ? '0 : s_reg + 1'b1;
            if (s_reg == S_V0) samp_next[0] = rx_s_reg;
            if (s_reg == S_V1) samp_next[1] = rx_s_reg;
        end

        case (state_reg)
            IDLE: begin
                if (!rx_s_reg) begin
                    state_next    = START;
                    s_next        = '0;
                    n_next        = '0;
                    stop_err_next = 1'b0;
                end
            end
            START: begin
                if (vote_now && vote)
                    state_next = IDLE;
                else if (bit_end)
                    state_next = DATA;
            end
            DATA: begin
                if (vote_now)
                    shift_next = {vote, shift_reg[DBIT-1:1]};
                if (bit_end) begin
                    if (n_reg == N_DATA_LAST) begin
                        n_next     = '0;
                        state_next = PEN ? PARITY : STOP;
                    end else begin
                        n_next = n_reg + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (vote_now)
                    par_next = vote;
                if (bit_end)
                    state_next = STOP;
            end
            STOP: begin
                // Finishing at mid-bit of the last stop leaves half a bit to catch the next start edge.
                if (vote_now) begin
                    if (n_reg == N_STOP_LAST) begin
                        done       = 1'b1;
                        state_next = done_brk ? BRK_WAIT : IDLE;
                    end else begin
                        stop_err_next = stop_err_reg | ~vote;
                    end
                end
                if (bit_end)
                    n_next = n_reg + 4'd1;
            end
            BRK_WAIT: begin
                if (rx_s_reg)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid   <= 1'b1;
                    rx_data    <= shift_reg;
                    parity_err <= done_perr;
                    frame_err  <= done_ferr;
                    break_det  <= done_brk;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1/x16 instance and a 7E2/x8 instance share one tick.
module tb_uart_rx_cfg;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_tick = 1'b0;
    logic [1:0] tick_cnt = 2'd0;
    logic       rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;

    logic       valid0, perr0, ferr0, brk0, ovr0;
    logic [7:0] data0;
    logic       valid1, perr1, ferr1, brk1, ovr1;
    logic [6:0] data1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0, errors = 0;
    int   ovr0_cnt = 0, ovr1_cnt = 0;
    bit   rand_ready = 1'b0;

    uart_rx_cfg u0 (
        .clk(clk), .rst(rst), .rx(rx0), .s_tick(s_tick), .rx_ready(rdy0),
        .rx_valid(valid0), .rx_data(data0), .parity_err(perr0),
        .frame_err(ferr0), .break_det(brk0), .overrun(ovr0)
    );

    uart_rx_cfg #(.DBIT(7), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .rx(rx1), .s_tick(s_tick), .rx_ready(rdy1),
        .rx_valid(valid1), .rx_data(data1), .parity_err(perr1),
        .frame_err(ferr1), .break_det(brk1), .overrun(ovr1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_cnt <= tick_cnt + 2'd1;
        s_tick   <= (tick_cnt == 2'd3);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, req);
        end
    endtask

    // Expected outcome of a frame from line-level rules: even parity over data+parity bit.
    function automatic exp_t model(input int inst, input logic [8:0] data, input logic par,
                                   input logic [1:0] stops);
        exp_t       e;
        int         nb    = (inst == 0) ? 8 : 7;
        int         ns    = (inst == 0) ? 1 : 2;
        bit         pen   = (inst == 1);
        logic [8:0] mask  = 9'((1 << nb) - 1);
        logic [8:0] d     = data & mask;
        int         ones  = $countones(d);
        logic       final_stop = stops[ns-1];
        e.data = d;
        e.perr = pen && (((ones + int'(par)) % 2) != 0);
        e.ferr = (stops[0] == 1'b0) || (ns == 2 && stops[1] == 1'b0);
        e.brk  = (d == 9'h0) && (!pen || par == 1'b0) && (final_stop == 1'b0);
        return e;
    endfunction

    task automatic deliver(input int inst, input logic [8:0] d, input logic p, input logic f,
                           input logic b);
        exp_t  e;
        string tag = (inst == 0) ? "u0" : "u1";
        $display("%s frame data=%0h perr=%0b ferr=%0b brk=%0b", tag, d, p, f, b);
        if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected frame got data %0h required none", tag, d);
            return;
        end
        if (inst == 0) e = q0.pop_front();
        else           e = q1.pop_front();
        check({tag, " data"}, 32'(d), 32'(e.data));
        check({tag, " parity_err"}, 32'(p), 32'(e.perr));
        check({tag, " frame_err"}, 32'(f), 32'(e.ferr));
        check({tag, " break_det"}, 32'(b), 32'(e.brk));
    endtask

    // Monitor: sample half a cycle away from the active edge.
    initial forever begin
        @(negedge clk);
        #1;
        if (valid0 && rdy0) deliver(0, {1'b0, data0}, perr0, ferr0, brk0);
        if (valid1 && rdy1) deliver(1, {2'b0, data1}, perr1, ferr1, brk1);
        if (ovr0) ovr0_cnt++;
        if (ovr1) ovr1_cnt++;
    end

    initial forever begin
        @(negedge clk);
        if (rand_ready) begin
            rdy0 = 1'($urandom_range(0, 1));
            rdy1 = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (!s_tick) @(negedge clk);
        end
    endtask

    task automatic drive(input int inst, input logic v);
        if (inst == 0) rx0 = v;
        else           rx1 = v;
    endtask

    task automatic send_frame(input int inst, input logic [8:0] data, input logic par,
                              input logic [1:0] stops, input bit lat_chk);
        int os = (inst == 0) ? 16 : 8;
        int m  = os / 2;
        int nb = (inst == 0) ? 8 : 7;
        int ns = (inst == 0) ? 1 : 2;
        drive(inst, 1'b0);
        wait_ticks(os);
        for (int i = 0; i < nb; i++) begin
            drive(inst, data[i]);
            wait_ticks(os);
        end
        if (inst == 1) begin
            drive(inst, par);
            wait_ticks(os);
        end
        for (int j = 0; j < ns; j++) begin
            drive(inst, stops[j]);
            if (j == ns - 1 && !stops[j]) begin
                // Low only through the sample window, so the line is idle again afterwards.
                wait_ticks(m + 3);
                drive(inst, 1'b1);
                wait_ticks(os - m - 3);
            end else if (j == ns - 1 && lat_chk) begin
                wait_ticks(m + 2);
                check("u0 valid before completing tick", 32'(valid0), 32'd0);
                @(negedge clk);
                check("u0 valid one cycle after completing tick", 32'(valid0), 32'd1);
                wait_ticks(os - m - 2);
            end else begin
                wait_ticks(os);
            end
        end
        drive(inst, 1'b1);
        wait_ticks(2 * os);
    endtask

    task automatic issue(input int inst, input logic [8:0] data, input logic par,
                         input logic [1:0] stops, input bit lat_chk);
        if (inst == 0) q0.push_back(model(inst, data, par, stops));
        else           q1.push_back(model(inst, data, par, stops));
        send_frame(inst, data, par, stops, lat_chk);
    endtask

    task automatic rand_frames(input int inst, input int n);
        logic [8:0] d;
        logic       par;
        logic [1:0] st;
        for (int k = 0; k < n; k++) begin
            d = ($urandom_range(0, 7) == 0) ? 9'h0 : 9'($urandom);
            par = 1'($countones(d[6:0]) % 2);
            if ($urandom_range(0, 3) == 0) par = ~par;
            st[0] = ($urandom_range(0, 7) != 0);
            st[1] = ($urandom_range(0, 7) != 0);
            issue(inst, d, par, st, 1'b0);
        end
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("u0 reset rx_valid", 32'(valid0), 32'd0);
        check("u0 reset rx_data", 32'(data0), 32'd0);
        check("u0 reset flags", 32'({perr0, ferr0, brk0}), 32'd0);
        check("u0 reset overrun", 32'(ovr0), 32'd0);
        check("u1 reset rx_valid", 32'(valid1), 32'd0);
        check("u1 reset overrun", 32'(ovr1), 32'd0);
        rst = 1'b0;
        wait_ticks(20);

        // 8N1 byte with output latency check
        issue(0, 9'hA5, 1'b0, 2'b11, 1'b1);

        // Short low glitch must be rejected, then a normal frame
        drive(0, 1'b0);
        wait_ticks(4);
        drive(0, 1'b1);
        wait_ticks(32);
        issue(0, 9'h3C, 1'b0, 2'b11, 1'b0);

        // 7E2: wrong then correct parity, then bad second stop bit
        issue(1, 9'h41, 1'b1, 2'b11, 1'b0);
        issue(1, 9'h41, 1'b0, 2'b11, 1'b0);
        issue(1, 9'h55, 1'b0, 2'b01, 1'b0);

        // Break: line low for 20 bit times yields exactly one frame
        q0.push_back(model(0, 9'h0, 1'b0, 2'b00));
        drive(0, 1'b0);
        wait_ticks(20 * 16);
        drive(0, 1'b1);
        wait_ticks(32);
        issue(0, 9'h5A, 1'b0, 2'b11, 1'b0);

        // Overrun: consumer stalled across two frames
        rdy0 = 1'b0;
        issue(0, 9'h11, 1'b0, 2'b11, 1'b0);
        check("u0 stalled rx_valid", 32'(valid0), 32'd1);
        check("u0 stalled rx_data", 32'(data0), 32'h11);
        send_frame(0, 9'h22, 1'b0, 2'b11, 1'b0);
        check("u0 overrun pulses", 32'(ovr0_cnt), 32'd1);
        check("u0 held rx_data", 32'(data0), 32'h11);
        rdy0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("u0 rx_valid after accept", 32'(valid0), 32'd0);
        check("u0 rx_data hold after accept", 32'(data0), 32'h11);

        // Reset in the middle of a frame aborts it
        wait_ticks(1);
        drive(0, 1'b0);
        wait_ticks(16);
        drive(0, 1'b1);
        wait_ticks(16);
        drive(0, 1'b0);
        wait_ticks(8);
        rst = 1'b1;
        rx0 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(48);
        check("u0 rx_valid after mid-frame reset", 32'(valid0), 32'd0);
        issue(0, 9'h96, 1'b0, 2'b11, 1'b0);

        // Randomized traffic with random consumer backpressure
        rand_ready = 1'b1;
        fork
            begin wait_ticks(1); rand_frames(0, 25); end
            begin wait_ticks(1); rand_frames(1, 25); end
        join
        rand_ready = 1'b0;
        @(negedge clk);
        rdy0 = 1'b1;
        rdy1 = 1'b1;
        wait_ticks(40);

        check("u0 frames still expected", 32'(q0.size()), 32'd0);
        check("u1 frames still expected", 32'(q1.size()), 32'd0);
        check("u0 total overrun pulses", 32'(ovr0_cnt), 32'd1);
        check("u1 total overrun pulses", 32'(ovr1_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
